// File: rtl/pr_sched_pkg.sv
// Shared types and widths for the partial-reconfiguration scheduler.
package pr_pkg;
  localparam int unsigned ADDR_W     = 27;
  localparam int unsigned LEN_W      = 20;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned SLOT_W_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PGRM,
    ST_WAIT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/pr_sched_if.sv
// Requester, slot-table, DMA/ICAP and status signals of pr_sched.
interface pr_sched_if
  import pr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SLOT_W  = SLOT_W_DEF
) ();
  logic                      i_tbl_wr_en;
  logic [SLOT_W-1:0]         i_tbl_wr_slot;
  logic [ADDR_W-1:0]         i_tbl_wr_addr;
  logic [LEN_W-1:0]          i_tbl_wr_len;
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*SLOT_W-1:0] i_req_slot;
  logic [NUM_REQ-1:0]        o_gnt;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_err;
  logic [ADDR_W-1:0]         o_ddr_strt_addr;
  logic [LEN_W-1:0]          o_trans_len;
  logic                      o_load;
  logic                      o_pgrm_icap;
  logic                      i_icap_done;
  logic [SLOT_W-1:0]         i_cnt_slot;
  logic [CNT_W-1:0]          o_cnt;
  logic [LEN_W-1:0]          o_last_cycles;

  modport slave (
    input  i_tbl_wr_en, i_tbl_wr_slot, i_tbl_wr_addr, i_tbl_wr_len,
    input  i_req, i_req_slot, i_icap_done, i_cnt_slot,
    output o_gnt, o_busy, o_done, o_err, o_ddr_strt_addr, o_trans_len,
    output o_load, o_pgrm_icap, o_cnt, o_last_cycles
  );

  modport master (
    output i_tbl_wr_en, i_tbl_wr_slot, i_tbl_wr_addr, i_tbl_wr_len,
    output i_req, i_req_slot, i_icap_done, i_cnt_slot,
    input  o_gnt, o_busy, o_done, o_err, o_ddr_strt_addr, o_trans_len,
    input  o_load, o_pgrm_icap, o_cnt, o_last_cycles
  );
endinterface

// File: rtl/pr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one above the last winner.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(last) + i) % NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!any && req[cand_idx]) begin
        any           = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end
endmodule

// File: rtl/pr_sched.sv
// Round-robin partial-reconfiguration scheduler: slot table, load/program/wait
// sequencing with timeout, per-slot success counts and last-wait cycle count.
module pr_sched
  import pr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SLOT_W  = SLOT_W_DEF,
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic       i_clk,
  input logic       i_rst,
  pr_sched_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned NSLOT = 2 ** SLOT_W;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]  tbl_addr [NSLOT];
  logic [LEN_W-1:0]   tbl_len  [NSLOT];
  logic [CNT_W-1:0]   cnt      [NSLOT];

  logic [NUM_REQ-1:0] arb_gnt, gnt_r;
  logic [IDX_W-1:0]   arb_idx, winner, last_win;
  logic               arb_any;
  logic [SLOT_W-1:0]  win_slot, slot;
  logic [ADDR_W-1:0]  addr_r;
  logic [LEN_W-1:0]   len_r, counter, last_cycles;
  logic               err;
  logic               timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req  (bus.i_req),
    .last (last_win),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign win_slot    = bus.i_req_slot[32'(arb_idx)*SLOT_W +: SLOT_W];
  assign timeout_hit = (counter == LEN_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (arb_any) state_nxt = (tbl_len[win_slot] == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: state_nxt = ST_PGRM;
      ST_PGRM: state_nxt = ST_WAIT;
      ST_WAIT: if (bus.i_icap_done || timeout_hit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < NSLOT; s++) begin
        tbl_addr[s] <= '0;
        tbl_len[s]  <= '0;
        cnt[s]      <= '0;
      end
      gnt_r       <= '0;
      winner      <= '0;
      last_win    <= IDX_W'(NUM_REQ - 1);
      slot        <= '0;
      addr_r      <= '0;
      len_r       <= '0;
      counter     <= '0;
      last_cycles <= '0;
      err         <= 1'b0;
    end else begin
      // The latch below reads the pre-write entry when both hit the same edge.
      if (bus.i_tbl_wr_en) begin
        tbl_addr[bus.i_tbl_wr_slot] <= bus.i_tbl_wr_addr;
        tbl_len[bus.i_tbl_wr_slot]  <= bus.i_tbl_wr_len;
      end
      unique case (state)
        ST_IDLE: if (arb_any) begin
          gnt_r  <= arb_gnt;
          winner <= arb_idx;
          slot   <= win_slot;
          addr_r <= tbl_addr[win_slot];
          len_r  <= tbl_len[win_slot];
          err    <= (tbl_len[win_slot] == '0);
        end
        ST_PGRM: counter <= '0;
        ST_WAIT: begin
          counter <= counter + 1'b1;
          if (!bus.i_icap_done && timeout_hit) err <= 1'b1;
        end
        ST_DONE: begin
          last_cycles <= counter;
          last_win    <= winner;
          if (!err) cnt[slot] <= cnt[slot] + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy          = (state != ST_IDLE);
  assign bus.o_load          = (state == ST_LOAD);
  assign bus.o_pgrm_icap     = (state == ST_PGRM);
  assign bus.o_done          = (state == ST_DONE);
  assign bus.o_err           = (state == ST_DONE) && err;
  assign bus.o_gnt           = (state == ST_DONE) ? gnt_r : '0;
  assign bus.o_ddr_strt_addr = addr_r;
  assign bus.o_trans_len     = len_r;
  assign bus.o_last_cycles   = last_cycles;
  assign bus.o_cnt           = cnt[bus.i_cnt_slot];
endmodule

// File: tb/tb_pr_sched.sv
// Scoreboard bench for pr_sched: directed transactions push expected completions,
// a negedge monitor pops and compares them whenever o_done is seen.
module tb_pr_sched;
  import pr_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned TO = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pr_sched_if #(.NUM_REQ(NR), .SLOT_W(SW)) bus ();

  pr_sched #(.NUM_REQ(NR), .SLOT_W(SW), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [NR-1:0]     gnt;
    logic              err;
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    int                loads;
    int                lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor
  int   load_cyc, pgrm_cyc, n_load, n_pgrm, lc_exp;
  bit   lc_pend;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      n_load  = 0;
      n_pgrm  = 0;
      lc_pend = 1'b0;
    end else begin
      if (lc_pend) begin
        chk("last_cycles", 64'(bus.o_last_cycles), 64'(lc_exp));
        lc_pend = 1'b0;
      end
      if (bus.o_load) begin
        load_cyc = cyc;
        n_load++;
      end
      if (bus.o_pgrm_icap) begin
        chk("pgrm_after_load", 64'(cyc), 64'(load_cyc + 1));
        pgrm_cyc = cyc;
        n_pgrm++;
      end
      if (bus.o_done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done required=none gnt=%b", bus.o_gnt);
        end else begin
          e = q.pop_front();
          chk("gnt",  64'(bus.o_gnt), 64'(e.gnt));
          chk("err",  64'(bus.o_err), 64'(e.err));
          chk("addr", 64'(bus.o_ddr_strt_addr), 64'(e.addr));
          chk("len",  64'(bus.o_trans_len), 64'(e.len));
          chk("n_load", 64'(n_load), 64'(e.loads));
          chk("n_pgrm", 64'(n_pgrm), 64'(e.loads));
          if (e.lat >= 0) chk("done_latency", 64'(cyc - pgrm_cyc), 64'(e.lat));
          if (e.cyc >= 0) begin
            lc_exp  = e.cyc;
            lc_pend = 1'b1;
          end
        end
        n_load = 0;
        n_pgrm = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NR-1:0] g, input logic er, input int c,
                      input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                      input int ld, input int lt);
    exp_t x;
    x.gnt = g; x.err = er; x.cyc = c; x.addr = a; x.len = l; x.loads = ld; x.lat = lt;
    q.push_back(x);
  endtask

  task automatic wr_tbl(input int s, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    bus.i_tbl_wr_en   = 1'b1;
    bus.i_tbl_wr_slot = SW'(s);
    bus.i_tbl_wr_addr = a;
    bus.i_tbl_wr_len  = l;
    tick();
    bus.i_tbl_wr_en   = 1'b0;
  endtask

  task automatic set_req(input int k, input int s);
    bus.i_req_slot[k*SW +: SW] = SW'(s);
    bus.i_req[k] = 1'b1;
  endtask

  task automatic wait_pgrm();
    int n = 0;
    while (!bus.o_pgrm_icap && n < 200) begin
      tick();
      n++;
    end
    if (!bus.o_pgrm_icap) begin
      checks++;
      errors++;
      $display("FAIL wait_pgrm actual=no_pulse required=o_pgrm_icap within 200 cycles");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.o_done && n < 200) begin
      tick();
      n++;
    end
    if (!bus.o_done) begin
      checks++;
      errors++;
      $display("FAIL wait_done actual=no_pulse required=o_done within 200 cycles");
    end
  endtask

  task automatic pulse_done(input int d);
    repeat (d) tick();
    bus.i_icap_done = 1'b1;
    tick();
    bus.i_icap_done = 1'b0;
  endtask

  task automatic serve(input int d);
    wait_pgrm();
    pulse_done(d);
    wait_done();
  endtask

  task automatic chk_cnt(input int s, input int v);
    bus.i_cnt_slot = SW'(s);
    #1;
    chk($sformatf("cnt_slot%0d", s), 64'(bus.o_cnt), 64'(v));
  endtask

  initial begin
    rst = 1'b1;
    bus.i_tbl_wr_en = 1'b0; bus.i_tbl_wr_slot = '0; bus.i_tbl_wr_addr = '0;
    bus.i_tbl_wr_len = '0; bus.i_req = '0; bus.i_req_slot = '0;
    bus.i_icap_done = 1'b0; bus.i_cnt_slot = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.o_busy), 0);
    chk("rst_gnt",  64'(bus.o_gnt), 0);
    chk("rst_done", 64'(bus.o_done), 0);
    chk("rst_load", 64'(bus.o_load), 0);
    chk("rst_addr", 64'(bus.o_ddr_strt_addr), 0);
    chk("rst_lastc", 64'(bus.o_last_cycles), 0);
    rst = 1'b0;
    tick();

    // Round robin from reset: all four requesting, grants 0,1,2,3,0
    wr_tbl(0, 27'h200, 20'd100);
    wr_tbl(2, 27'h300, 20'd200);
    wr_tbl(3, 27'h400, 20'd300);
    set_req(0, 0); set_req(1, 2); set_req(2, 3); set_req(3, 0);
    push(4'b0001, 1'b0, 3, 27'h200, 20'd100, 1, 4);
    push(4'b0010, 1'b0, 3, 27'h300, 20'd200, 1, 4);
    push(4'b0100, 1'b0, 3, 27'h400, 20'd300, 1, 4);
    push(4'b1000, 1'b0, 3, 27'h200, 20'd100, 1, 4);
    push(4'b0001, 1'b0, 3, 27'h200, 20'd100, 1, 4);
    for (int i = 0; i < 5; i++) begin
      serve(3);
      if (i == 4) bus.i_req = '0;
    end
    tick();
    chk("rr_idle_after", 64'(bus.o_busy), 0);
    chk_cnt(0, 3);
    chk_cnt(2, 1);

    // Basic transfer, done 10 cycles after program pulse
    wr_tbl(1, 27'h100, 20'd500);
    push(4'b0001, 1'b0, 10, 27'h100, 20'd500, 1, 11);
    set_req(0, 1);
    serve(10);
    bus.i_req = '0;
    tick();
    chk_cnt(1, 1);

    // Timeout: no done, exactly TO wait cycles, count unchanged
    push(4'b0010, 1'b1, 50, 27'h300, 20'd200, 1, 51);
    set_req(1, 2);
    wait_pgrm();
    wait_done();
    bus.i_req = '0;
    tick();
    chk_cnt(2, 1);

    // Zero-length entry: done+err one cycle after request, no load/program
    wr_tbl(3, 27'h555, 20'd0);
    push(4'b0100, 1'b1, -1, 27'h555, 20'd0, 0, -1);
    set_req(2, 3);
    tick();
    chk("zl_done", 64'(bus.o_done), 1);
    chk("zl_err",  64'(bus.o_err), 1);
    bus.i_req = '0;
    tick();
    chk_cnt(3, 1);

    // Table rewrite during WAIT does not disturb the active transfer
    push(4'b0001, 1'b0, 5, 27'h100, 20'd500, 1, 6);
    set_req(0, 1);
    wait_pgrm();
    tick();
    wr_tbl(1, 27'h1234, 20'd77);
    chk("hold_addr", 64'(bus.o_ddr_strt_addr), 64'h100);
    chk("hold_len",  64'(bus.o_trans_len), 64'd500);
    pulse_done(3);
    wait_done();
    bus.i_req = '0;
    tick();
    // Next grant sees the new entry; request dropped mid-service still completes
    push(4'b0001, 1'b0, 2, 27'h1234, 20'd77, 1, 3);
    set_req(0, 1);
    wait_pgrm();
    bus.i_req = '0;
    pulse_done(2);
    wait_done();
    tick();
    chk_cnt(1, 3);

    // Success counter wraps at 8 bits
    for (int i = 0; i < 255; i++) begin
      push(4'b1000, 1'b0, 1, 27'h300, 20'd200, 1, 2);
      set_req(3, 2);
      serve(1);
      bus.i_req = '0;
      tick();
      if (i == 253) chk_cnt(2, 255);
    end
    chk_cnt(2, 0);

    // Reset during WAIT clears everything
    set_req(0, 1);
    wait_pgrm();
    tick();
    tick();
    rst = 1'b1;
    tick();
    bus.i_req = '0;
    chk("wrst_busy", 64'(bus.o_busy), 0);
    chk("wrst_load", 64'(bus.o_load | bus.o_pgrm_icap | bus.o_done | bus.o_err), 0);
    chk("wrst_gnt",  64'(bus.o_gnt), 0);
    chk("wrst_addr", 64'(bus.o_ddr_strt_addr), 0);
    chk("wrst_len",  64'(bus.o_trans_len), 0);
    chk("wrst_lastc", 64'(bus.o_last_cycles), 0);
    chk_cnt(0, 0);
    chk_cnt(1, 0);
    rst = 1'b0;
    tick();

    // Cleared table gives zero-length; pointer back to requester 0 first
    push(4'b0001, 1'b1, -1, 27'h0, 20'd0, 0, -1);
    for (int k = 0; k < 4; k++) set_req(k, 1);
    tick();
    chk("post_rst_done", 64'(bus.o_done), 1);
    bus.i_req = '0;
    tick();
    tick();
    chk("queue_empty", 64'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
